// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared definitions for the Tetris game-step datapath.
//   - act_e   : opcodes understood by the combinational move ALU
//   - state_e : move_ctrl FSM states (also visible on move_ctrl.dbg_state)
//   - SPAWN_X and the spawn-piece shape (vertical I piece, cell3 on top)
package tetris_pkg;

    typedef enum logic [2:0] {
        ACT_LOAD  = 3'd0,
        ACT_DOWN  = 3'd1,
        ACT_LEFT  = 3'd2,
        ACT_RIGHT = 3'd3,
        ACT_ROTR  = 3'd4
    } act_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CHECK = 3'd2,
        S_LOCK  = 3'd3,
        S_SPAWN = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    localparam int SPAWN_X     = 4;
    localparam int PIECE_CELLS = 4;

    // Spawn piece is a vertical bar: cell3 at row 0 down to cell0 at row 3.
    function automatic int spawn_cell_y(input int k);
        return PIECE_CELLS - 1 - k;
    endfunction

endpackage

// File: rtl/piece_fit.sv
// piece_fit
//   Combinational fit check of a four-cell piece against the skyline.
//   A cell fits when its column is inside the field and its row lies
//   strictly above the topmost occupied row of that column.
// Ports
//   cell_x, cell_y : in  4*WIDTH    cell k in slice [k*WIDTH +: WIDTH]
//   border         : in  MEM_WIDTH*WIDTH  skyline, byte c = column c
//   fits           : out 1          all four cells fit
module piece_fit #(
    parameter int WIDTH     = 8,
    parameter int MEM_WIDTH = 10
) (
    input  logic [4*WIDTH-1:0]         cell_x,
    input  logic [4*WIDTH-1:0]         cell_y,
    input  logic [MEM_WIDTH*WIDTH-1:0] border,
    output logic                       fits
);

    logic [WIDTH-1:0] limit;

    always_comb begin
        fits  = 1'b1;
        limit = '0;
        for (int k = 0; k < 4; k++) begin
            // Columns outside the field leave limit at 0, so no row can fit;
            // this also rejects a left move that wrapped from 0 to all-ones.
            limit = '0;
            for (int c = 0; c < MEM_WIDTH; c++) begin
                if (cell_x[k*WIDTH +: WIDTH] == WIDTH'(c)) begin
                    limit = border[c*WIDTH +: WIDTH];
                end
            end
            if (cell_y[k*WIDTH +: WIDTH] >= limit) begin
                fits = 1'b0;
            end
        end
    end

endmodule

// File: rtl/move_ctrl.sv
// move_ctrl
//   Game-step controller on the request side of the move ALU. Gravity ticks
//   and button edges become pending requests; one is served per transaction
//   (ISSUE -> CHECK). A proposal that fits is committed, a failed down move
//   locks the piece into the skyline and respawns, anything else is dropped.
// Ports
//   clk, rst (async, active low)
//   tick, btn_left, btn_right, btn_rot : requests (buttons are raw levels)
//   new_rho_x, new_rho_y : ALU proposal, cell k in [k*WIDTH +: WIDTH]
//   action, is_move      : ALU opcode / enable, valid only in ISSUE
//   rho_x, rho_y         : committed piece cells
//   border               : skyline, byte c = top occupied row or MEM_HEIGHT
//   lock_pulse, pieces, game_over : lock event, lock count, sticky end flag
//   dbg_state            : current FSM state (tetris_pkg::state_e encoding)
// Handshake: the ALU is purely combinational; is_move qualifies action for
// the single ISSUE cycle and the proposal is sampled at the end of it.
module move_ctrl #(
    parameter int WIDTH      = 8,
    parameter int MEM_WIDTH  = 10,
    parameter int MEM_HEIGHT = 20,
    parameter int SPAWN_X    = tetris_pkg::SPAWN_X
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_rot,
    input  logic [4*WIDTH-1:0]         new_rho_x,
    input  logic [4*WIDTH-1:0]         new_rho_y,
    output logic [WIDTH-1:0]           action,
    output logic                       is_move,
    output logic [4*WIDTH-1:0]         rho_x,
    output logic [4*WIDTH-1:0]         rho_y,
    output logic [MEM_WIDTH*WIDTH-1:0] border,
    output logic                       lock_pulse,
    output logic [15:0]                pieces,
    output logic                       game_over,
    output logic [2:0]                 dbg_state
);

    import tetris_pkg::*;

    localparam int CW = 4 * WIDTH;
    localparam int BW = MEM_WIDTH * WIDTH;
    localparam logic [WIDTH-1:0] HEIGHT_W = WIDTH'(MEM_HEIGHT);
    localparam logic [BW-1:0] BORDER_EMPTY = {MEM_WIDTH{HEIGHT_W}};

    function automatic logic [CW-1:0] spawn_vec(input logic want_y);
        logic [CW-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[k*WIDTH +: WIDTH] = want_y ? WIDTH'(spawn_cell_y(k)) : WIDTH'(SPAWN_X);
        end
        return v;
    endfunction

    localparam logic [CW-1:0] SPAWN_RHO_X = spawn_vec(1'b0);
    localparam logic [CW-1:0] SPAWN_RHO_Y = spawn_vec(1'b1);

    state_e          state_q, state_d;
    act_e            op_q, op_d;
    logic            p_down_q, p_down_d;
    logic            p_rot_q, p_rot_d;
    logic            p_left_q, p_left_d;
    logic            p_right_q, p_right_d;
    logic            btn_left_q, btn_right_q, btn_rot_q;
    logic [CW-1:0]   rho_x_q, rho_x_d;
    logic [CW-1:0]   rho_y_q, rho_y_d;
    logic [CW-1:0]   cand_x_q, cand_x_d;
    logic [CW-1:0]   cand_y_q, cand_y_d;
    logic [BW-1:0]   border_q, border_d;
    logic [15:0]     pieces_q, pieces_d;
    logic            game_over_q, game_over_d;

    logic            rise_left, rise_right, rise_rot;
    logic            clr_down, clr_rot, clr_left, clr_right;
    logic            cand_fits, spawn_fits;
    logic [BW-1:0]   lock_border;

    piece_fit #(.WIDTH(WIDTH), .MEM_WIDTH(MEM_WIDTH)) u_cand_fit (
        .cell_x (cand_x_q),
        .cell_y (cand_y_q),
        .border (border_q),
        .fits   (cand_fits)
    );

    // In SPAWN the skyline already includes the piece locked in LOCK.
    piece_fit #(.WIDTH(WIDTH), .MEM_WIDTH(MEM_WIDTH)) u_spawn_fit (
        .cell_x (SPAWN_RHO_X),
        .cell_y (SPAWN_RHO_Y),
        .border (border_q),
        .fits   (spawn_fits)
    );

    assign rise_left  = btn_left  & ~btn_left_q;
    assign rise_right = btn_right & ~btn_right_q;
    assign rise_rot   = btn_rot   & ~btn_rot_q;

    // Skyline after dropping the committed piece in: per column, the
    // smallest row among cells in that column, if it is above the old top.
    always_comb begin
        lock_border = border_q;
        for (int c = 0; c < MEM_WIDTH; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (rho_x_q[k*WIDTH +: WIDTH] == WIDTH'(c) &&
                    rho_y_q[k*WIDTH +: WIDTH] < lock_border[c*WIDTH +: WIDTH]) begin
                    lock_border[c*WIDTH +: WIDTH] = rho_y_q[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rho_x_d     = rho_x_q;
        rho_y_d     = rho_y_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        border_d    = border_q;
        pieces_d    = pieces_q;
        game_over_d = game_over_q;
        action      = '0;
        is_move     = 1'b0;
        clr_down    = 1'b0;
        clr_rot     = 1'b0;
        clr_left    = 1'b0;
        clr_right   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (p_down_q) begin
                    op_d     = ACT_DOWN;
                    clr_down = 1'b1;
                    state_d  = S_ISSUE;
                end else if (p_rot_q) begin
                    op_d     = ACT_ROTR;
                    clr_rot  = 1'b1;
                    state_d  = S_ISSUE;
                end else if (p_left_q) begin
                    op_d     = ACT_LEFT;
                    clr_left = 1'b1;
                    state_d  = S_ISSUE;
                end else if (p_right_q) begin
                    op_d      = ACT_RIGHT;
                    clr_right = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                action   = WIDTH'(op_q);
                is_move  = 1'b1;
                cand_x_d = new_rho_x;
                cand_y_d = new_rho_y;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (cand_fits) begin
                    rho_x_d = cand_x_q;
                    rho_y_d = cand_y_q;
                    state_d = S_IDLE;
                end else if (op_q == ACT_DOWN) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                border_d = lock_border;
                pieces_d = pieces_q + 16'd1;
                state_d  = S_SPAWN;
            end
            S_SPAWN: begin
                rho_x_d = SPAWN_RHO_X;
                rho_y_d = SPAWN_RHO_Y;
                if (!spawn_fits) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new request in the same cycle its bit is served stays pending,
        // so it is not lost; repeats before service collapse into one bit.
        if (state_q == S_OVER) begin
            p_down_d  = 1'b0;
            p_rot_d   = 1'b0;
            p_left_d  = 1'b0;
            p_right_d = 1'b0;
        end else begin
            p_down_d  = (p_down_q  & ~clr_down)  | tick;
            p_rot_d   = (p_rot_q   & ~clr_rot)   | rise_rot;
            p_left_d  = (p_left_q  & ~clr_left)  | rise_left;
            p_right_d = (p_right_q & ~clr_right) | rise_right;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= ACT_LOAD;
            p_down_q    <= 1'b0;
            p_rot_q     <= 1'b0;
            p_left_q    <= 1'b0;
            p_right_q   <= 1'b0;
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
            btn_rot_q   <= 1'b0;
            rho_x_q     <= SPAWN_RHO_X;
            rho_y_q     <= SPAWN_RHO_Y;
            cand_x_q    <= SPAWN_RHO_X;
            cand_y_q    <= SPAWN_RHO_Y;
            border_q    <= BORDER_EMPTY;
            pieces_q    <= 16'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            p_down_q    <= p_down_d;
            p_rot_q     <= p_rot_d;
            p_left_q    <= p_left_d;
            p_right_q   <= p_right_d;
            btn_left_q  <= btn_left;
            btn_right_q <= btn_right;
            btn_rot_q   <= btn_rot;
            rho_x_q     <= rho_x_d;
            rho_y_q     <= rho_y_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            border_q    <= border_d;
            pieces_q    <= pieces_d;
            game_over_q <= game_over_d;
        end
    end

    assign rho_x      = rho_x_q;
    assign rho_y      = rho_y_q;
    assign border     = border_q;
    assign pieces     = pieces_q;
    assign game_over  = game_over_q;
    assign lock_pulse = (state_q == S_LOCK);
    assign dbg_state  = state_q;

endmodule

// File: doc/move_ctrl.md
# move_ctrl

Game-step controller for the base Tetris datapath; it sits on the request side of the combinational move ALU. It turns gravity ticks and button edges into ALU actions, drives `action`/`is_move`, and captures the ALU's proposed `new_rho_x/new_rho_y`. It checks each proposal against the field, then commits it, discards it, or locks the piece into the border, respawns, and flags game over.

## Interface
- `WIDTH`, 8: coordinate/byte width.
- `MEM_WIDTH`, 10: field columns.
- `MEM_HEIGHT`, 20: field rows; border value meaning "column empty".
- `SPAWN_X`, 4: spawn column.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `tick`  in  1  gravity pulse, one cycle.
- `btn_left`, `btn_right`, `btn_rot`  in  1 each  raw button levels; edge-detected internally.
- `new_rho_x`, `new_rho_y`  in  4*WIDTH each  ALU proposal; cell k occupies slice [k*WIDTH +: WIDTH].
- `action`  out  WIDTH  ALU opcode: 0 load, 1 down, 2 left, 3 right, 4 rotR.
- `is_move`  out  1  ALU enable.
- `rho_x`, `rho_y`  out  4*WIDTH each  committed piece cells.
- `border`  out  MEM_WIDTH*WIDTH  skyline; byte c holds the topmost occupied row of column c, or MEM_HEIGHT if the column is empty.
- `lock_pulse`  out  1  one cycle per lock.
- `pieces`  out  16  count of locked pieces.
- `game_over`  out  1  sticky until reset.

## Operation
- Reset values:
  - FSM in IDLE; pending bits 0; button edge registers 0.
  - `rho_x` = 4 in every cell; `rho_y` cell3..cell0 = 0,1,2,3.
  - Every `border` byte = MEM_HEIGHT.
  - `action`=0, `is_move`=0, `lock_pulse`=0, `pieces`=0, `game_over`=0.
- Requests:
  - A `tick`, or a rising edge on a button, sets a pending bit: `p_down`, `p_rot`, `p_left`, or `p_right`.
  - Pending bits are set in any state except OVER.
  - A pending bit is cleared when IDLE selects it.
  - Selection priority: down > rot > left > right. One request is served per transaction; the others stay pending.
- FSM states:
  - IDLE: if any pending bit is set, latch the selected opcode and go to ISSUE.
  - ISSUE: drive `action`=opcode and `is_move`=1 for exactly this cycle. Register `new_rho_x/y` into the candidate registers. Go to CHECK.
  - CHECK: evaluate fit. If the candidate fits, commit it to `rho` and go to IDLE. If it does not fit and the opcode is down, go to LOCK. Otherwise discard it and go to IDLE.
  - LOCK: for each column c, `border[c]` = min(`border[c]`, smallest y of the cells with x == c). Increment `pieces` and pulse `lock_pulse`. Go to SPAWN.
  - SPAWN: load the spawn piece into `rho`. If `border[SPAWN_X]` <= 3, set `game_over` and go to OVER; otherwise go to IDLE.
  - OVER: terminal. `is_move` stays 0, requests are ignored, pending bits are cleared.
- Fit rule: all four cells must satisfy x < MEM_WIDTH and y < border[x], compared unsigned.
  - Left from x=0 wraps to 255 and is rejected.
  - A cell with y ≥ MEM_HEIGHT is rejected.
- Outside ISSUE: `action`=0, `is_move`=0.

## Timing
- Transaction = ISSUE + CHECK + return to IDLE.
- A `tick` in cycle t while IDLE with nothing pending:
  - pending bit set at the end of t;
  - ISSUE in t+2;
  - new `rho` visible in t+4.
- A lock adds 2 cycles (LOCK, SPAWN); the spawned piece is visible 2 cycles after CHECK.
- Requests arriving while the FSM is busy are queued; a repeat of the same request before it is served collapses into one.
- `rst` asserted in any state returns every register to its reset value asynchronously. No partial commit or lock survives.

## Structure
- Shared `tetris_pkg`:
  - action encodings ACT_LOAD, ACT_DOWN, ACT_LEFT, ACT_RIGHT, ACT_ROTR;
  - state enum;
  - SPAWN_X and the spawn-piece constants.
- Sub-module `piece_fit`: combinational fit check of four cells against the border, reused by CHECK and SPAWN.
- The ALU is instantiated at the top level, not inside this block.

## Test plan
- Reset, one `tick` -> `is_move`=1 with `action`=1 for exactly one cycle; `rho_y` = 1,2,3,4 (cell3..0) four cycles after the tick.
- Five `btn_left` edges from spawn -> x goes 3,2,1,0; the fifth is rejected, x stays 0, and no lock occurs.
- `btn_rot` at spawn -> `rho_x` cell3..0 = 7,6,5,4, `rho_y` all 3. A second rotate -> x all 4, y = 3,4,5,6.
- 17 ticks from spawn -> after 16, y = 16..19. The 17th locks: `border[4]`=16, `pieces`=1, one `lock_pulse`, new piece at y 0..3.
- Five pieces dropped in column 4 -> `border[4]` = 16,12,8,4,0. After the fifth lock `game_over`=1 and `pieces`=5; a further tick produces no `is_move`.
- `tick` and `btn_left` in the same cycle -> two transactions, down first; final cells x=3, y=1..4. `rst` pulsed during CHECK -> reset values, no commit.
